// File: rtl/register_scoreboard.sv
// Register write scoreboard for the 5-stage pipeline.
// Keeps one pending-write counter per architectural register, plus the
// destination of a load sitting in EXE. It drives the ID-stage stall from
// that state: full scoreboard stall, or load-use only when forwarding is on.
module register_scoreboard #(
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4,
    parameter int CNT_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                forwardingEnabled,
    input  logic                twoSrc,
    input  logic [ADDR_W-1:0]   src1,
    input  logic [ADDR_W-1:0]   src2,
    input  logic                issue_valid,
    input  logic                issue_wb_en,
    input  logic                issue_mem_read,
    input  logic [ADDR_W-1:0]   issue_dest,
    input  logic                retire_valid,
    input  logic [ADDR_W-1:0]   retire_dest,
    output logic                hazard,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic [2:0]          in_flight,
    output logic                overflow_err,
    output logic                underflow_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    // Wide enough to hold NUM_REGS saturated counters before clamping.
    localparam int SUM_W = CNT_W + $clog2(NUM_REGS) + 1;

    logic [CNT_W-1:0]    cnt      [NUM_REGS];
    logic [CNT_W-1:0]    cnt_next [NUM_REGS];
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic [NUM_REGS-1:0] busy_next;
    logic [SUM_W-1:0]    sum_next;
    logic [2:0]          in_flight_next;
    logic                accept;
    logic                ovf_hit;
    logic                unf_hit;
    logic                ld_valid;
    logic [ADDR_W-1:0]   ld_dest;

    // Stall decision from registered state and the ID operands only.
    always_comb begin
        hazard = 1'b0;
        if (forwardingEnabled) begin
            hazard = ld_valid & ((src1 == ld_dest) | (twoSrc & (src2 == ld_dest)));
        end else begin
            hazard = (cnt[src1] != '0) | (twoSrc & (cnt[src2] != '0));
        end
    end

    // An issue is recorded only when it really leaves ID.
    always_comb begin
        accept = issue_valid & issue_wb_en & ~hazard;
    end

    // Decode the issue and retire ports into per-register strobes.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            inc_vec[r] = accept & (issue_dest == ADDR_W'(r));
            dec_vec[r] = retire_valid & (retire_dest == ADDR_W'(r));
        end
    end

    // Next counter values with saturation, plus error detection.
    always_comb begin
        ovf_hit = 1'b0;
        unf_hit = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_next[r] = cnt[r];
            // Matching issue and retire cancel; no error either way.
            if (inc_vec[r] && !dec_vec[r]) begin
                if (cnt[r] == CNT_MAX) begin
                    ovf_hit = 1'b1;
                end else begin
                    cnt_next[r] = cnt[r] + 1'b1;
                end
            end else if (dec_vec[r] && !inc_vec[r]) begin
                if (cnt[r] == '0) begin
                    unf_hit = 1'b1;
                end else begin
                    cnt_next[r] = cnt[r] - 1'b1;
                end
            end
        end
    end

    // Summary views of the post-edge counters: busy bits and clamped total.
    always_comb begin
        busy_next = '0;
        sum_next  = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_next[r] = (cnt_next[r] != '0);
            sum_next     = sum_next + SUM_W'(cnt_next[r]);
        end
        in_flight_next = (sum_next > SUM_W'(7)) ? 3'd7 : sum_next[2:0];
    end

    // Counters, summaries, load tracking and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= '0;
            end
            busy_mask     <= '0;
            in_flight     <= '0;
            ld_valid      <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt[r] <= cnt_next[r];
            end
            busy_mask     <= busy_next;
            in_flight     <= in_flight_next;
            ld_valid      <= accept & issue_mem_read;
            overflow_err  <= overflow_err | ovf_hit;
            underflow_err <= underflow_err | unf_hit;
        end
    end

    // Load destination is only meaningful while ld_valid is set.
    always_ff @(posedge clk) begin
        ld_dest <= issue_dest;
    end

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed bench for register_scoreboard with a queue-based scoreboard.
module tb_register_scoreboard;

    logic        clk;
    logic        rst;
    logic        forwardingEnabled;
    logic        twoSrc;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        issue_valid;
    logic        issue_wb_en;
    logic        issue_mem_read;
    logic [3:0]  issue_dest;
    logic        retire_valid;
    logic [3:0]  retire_dest;
    logic        hazard;
    logic [15:0] busy_mask;
    logic [2:0]  in_flight;
    logic        overflow_err;
    logic        underflow_err;

    register_scoreboard #(.NUM_REGS(16), .ADDR_W(4), .CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .forwardingEnabled(forwardingEnabled), .twoSrc(twoSrc),
        .src1(src1), .src2(src2),
        .issue_valid(issue_valid), .issue_wb_en(issue_wb_en),
        .issue_mem_read(issue_mem_read), .issue_dest(issue_dest),
        .retire_valid(retire_valid), .retire_dest(retire_dest),
        .hazard(hazard), .busy_mask(busy_mask), .in_flight(in_flight),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    // mask bits: 0 hazard, 1 busy_mask, 2 in_flight, 3 overflow, 4 underflow
    typedef struct {
        int          cyc;
        logic [4:0]  m;
        logic        hz;
        logic [15:0] bm;
        logic [2:0]  inf;
        logic        ov;
        logic        un;
        string       name;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation due in the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            if (e.cyc < cyc) begin
                checks++; failures++;
                $display("FAIL %s stale expectation cyc=%0d now=%0d", e.name, e.cyc, cyc);
            end else begin
                if (e.m[0]) begin
                    checks++;
                    if (hazard !== e.hz) begin
                        failures++;
                        $display("FAIL %s hazard got=%b exp=%b", e.name, hazard, e.hz);
                    end
                end
                if (e.m[1]) begin
                    checks++;
                    if (busy_mask !== e.bm) begin
                        failures++;
                        $display("FAIL %s busy_mask got=%h exp=%h", e.name, busy_mask, e.bm);
                    end
                end
                if (e.m[2]) begin
                    checks++;
                    if (in_flight !== e.inf) begin
                        failures++;
                        $display("FAIL %s in_flight got=%0d exp=%0d", e.name, in_flight, e.inf);
                    end
                end
                if (e.m[3]) begin
                    checks++;
                    if (overflow_err !== e.ov) begin
                        failures++;
                        $display("FAIL %s overflow_err got=%b exp=%b", e.name, overflow_err, e.ov);
                    end
                end
                if (e.m[4]) begin
                    checks++;
                    if (underflow_err !== e.un) begin
                        failures++;
                        $display("FAIL %s underflow_err got=%b exp=%b", e.name, underflow_err, e.un);
                    end
                end
            end
        end
    end

    task automatic idle();
        forwardingEnabled = 1'b0;
        twoSrc         = 1'b0;
        src1           = 4'd0;
        src2           = 4'd0;
        issue_valid    = 1'b0;
        issue_wb_en    = 1'b0;
        issue_mem_read = 1'b0;
        issue_dest     = 4'd0;
        retire_valid   = 1'b0;
        retire_dest    = 4'd0;
    endtask

    task automatic issue(input logic [3:0] d, input logic ld);
        issue_valid    = 1'b1;
        issue_wb_en    = 1'b1;
        issue_mem_read = ld;
        issue_dest     = d;
    endtask

    task automatic retire(input logic [3:0] d);
        retire_valid = 1'b1;
        retire_dest  = d;
    endtask

    task automatic chk(input logic [4:0] m, input logic hz, input logic [15:0] bm,
                       input logic [2:0] inf, input logic ov, input logic un,
                       input string name);
        exp_t x;
        x.cyc = cyc; x.m = m; x.hz = hz; x.bm = bm; x.inf = inf;
        x.ov = ov; x.un = un; x.name = name;
        q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        tick();
        chk(5'b11111, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, "reset");
        tick();
        rst = 1'b0;

        // Issue R3, then a dependent read stalls.
        idle(); issue(4'd3, 1'b0); tick();
        idle(); src1 = 4'd3;
        chk(5'b00111, 1'b1, 16'h0008, 3'd1, 1'b0, 1'b0, "r3_busy");
        tick();
        // Retire R3 while still reading it; a stalled issue to R6 is dropped.
        idle(); src1 = 4'd3; retire(4'd3); issue(4'd6, 1'b0);
        chk(5'b00011, 1'b1, 16'h0008, 3'd1, 1'b0, 1'b0, "r3_retire_same_cycle");
        tick();
        idle(); src1 = 4'd3;
        chk(5'b00111, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, "r3_released");
        tick();

        // Two issues to R5, two retires.
        idle(); issue(4'd5, 1'b0); tick();
        idle(); issue(4'd5, 1'b0);
        chk(5'b00110, 1'b0, 16'h0020, 3'd1, 1'b0, 1'b0, "r5_one");
        tick();
        idle(); retire(4'd5);
        chk(5'b00110, 1'b0, 16'h0020, 3'd2, 1'b0, 1'b0, "r5_two");
        tick();
        idle(); retire(4'd5);
        chk(5'b00110, 1'b0, 16'h0020, 3'd1, 1'b0, 1'b0, "r5_after_retire1");
        tick();
        idle();
        chk(5'b00110, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, "r5_clear");
        tick();

        // Same-cycle issue and retire of R7 cancel.
        idle(); issue(4'd7, 1'b0); tick();
        idle(); issue(4'd7, 1'b0); retire(4'd7); tick();
        idle();
        chk(5'b11110, 1'b0, 16'h0080, 3'd1, 1'b0, 1'b0, "r7_cancel");
        tick();
        idle(); retire(4'd7); tick();
        idle();
        chk(5'b00110, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, "r7_clear");
        tick();

        // Forwarding: load to R2, load-use on src2.
        idle(); forwardingEnabled = 1'b1; issue(4'd2, 1'b1); tick();
        idle(); forwardingEnabled = 1'b1; twoSrc = 1'b1; src2 = 4'd2;
        chk(5'b00011, 1'b1, 16'h0004, 3'd1, 1'b0, 1'b0, "fwd_load_use");
        tick();
        idle(); forwardingEnabled = 1'b1; twoSrc = 1'b1; src2 = 4'd2;
        chk(5'b00011, 1'b0, 16'h0004, 3'd1, 1'b0, 1'b0, "fwd_load_passed");
        tick();
        // Switching forwarding off makes the pending write stall again.
        idle(); twoSrc = 1'b1; src2 = 4'd2; retire(4'd2);
        chk(5'b00001, 1'b1, 16'h0004, 3'd1, 1'b0, 1'b0, "nofwd_busy_r2");
        tick();
        // Forwarding: non-load to R4 never stalls.
        idle(); forwardingEnabled = 1'b1; issue(4'd4, 1'b0); tick();
        idle(); forwardingEnabled = 1'b1; src1 = 4'd4; retire(4'd4);
        chk(5'b00111, 1'b0, 16'h0010, 3'd1, 1'b0, 1'b0, "fwd_nonload");
        tick();
        idle();
        chk(5'b00110, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, "r4_clear");
        tick();

        // Overflow: four issues to R1.
        for (int i = 0; i < 3; i++) begin
            idle(); issue(4'd1, 1'b0); tick();
        end
        idle(); issue(4'd1, 1'b0);
        chk(5'b01110, 1'b0, 16'h0002, 3'd3, 1'b0, 1'b0, "r1_at_max");
        tick();
        // Underflow: retire R9 at zero.
        idle(); retire(4'd9);
        chk(5'b11110, 1'b0, 16'h0002, 3'd3, 1'b1, 1'b0, "overflow_set");
        tick();
        idle(); issue(4'd10, 1'b0);
        chk(5'b11110, 1'b0, 16'h0002, 3'd3, 1'b1, 1'b1, "underflow_set");
        tick();

        // in_flight clamps at 7 (3 + 3 + 2 = 8).
        idle(); issue(4'd10, 1'b0); tick();
        idle(); issue(4'd10, 1'b0); tick();
        idle(); issue(4'd11, 1'b0); tick();
        idle(); issue(4'd11, 1'b0); tick();
        idle();
        chk(5'b00110, 1'b0, 16'h0C02, 3'd7, 1'b0, 1'b0, "in_flight_clamp");
        tick();

        // Reset mid-operation wins over a concurrent issue.
        idle(); rst = 1'b1; issue(4'd13, 1'b0); tick();
        rst = 1'b0; idle(); src1 = 4'd1;
        chk(5'b11111, 1'b0, 16'h0000, 3'd0, 1'b0, 1'b0, "mid_reset");
        tick();

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && q.size() > 0; i++) tick();
        if (q.size() > 0) begin
            checks++; failures++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/register_scoreboard.md
Name: register_scoreboard

Overview:
- Issue/retire bookkeeping for register writes in the 5-stage ARM pipeline.
- Tracks, per architectural register, how many issued instructions have not yet written it back.
- Records each writeback-enabled instruction as it leaves ID and releases it at WB.
- Drives the ID-stage stall (hazard) from this state instead of comparing against EXE/MEM destination buses, with a load-use-only stall mode when forwarding is enabled.

Parameters:
- NUM_REGS, 16, number of tracked architectural registers (R0–R15).
- ADDR_W, 4, register index width; must equal clog2(NUM_REGS).
- CNT_W, 2, per-register pending counter width; saturates at 2**CNT_W-1.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst  input  1  synchronous active-high reset.
- forwardingEnabled  input  1  1 = only load-use dependencies stall.
- twoSrc  input  1  ID instruction reads src2.
- src1  input  ADDR_W  ID source register 1.
- src2  input  ADDR_W  ID source register 2.
- issue_valid  input  1  ID instruction advances to EXE this cycle (not frozen, not flushed).
- issue_wb_en  input  1  issuing instruction writes a register.
- issue_mem_read  input  1  issuing instruction is a load.
- issue_dest  input  ADDR_W  destination of the issuing instruction.
- retire_valid  input  1  WB stage writes the register file this cycle.
- retire_dest  input  ADDR_W  WB destination.
- hazard  output  1  stall ID/IF this cycle.
- busy_mask  output  NUM_REGS  bit r = register r has pending writes.
- in_flight  output  3  total pending writes, saturating at 7.
- overflow_err  output  1  sticky: issue to a saturated counter.
- underflow_err  output  1  sticky: retire to a zero counter.

Behaviour:
- Reset values: all counters 0, load-tracking cleared, hazard 0, busy_mask 0, in_flight 0, both error flags 0.
- Issue accept:
  - accept = issue_valid & issue_wb_en & ~hazard.
  - An issue_valid asserted while hazard=1 is ignored; upstream is stalled.
- Counter update at the clock edge, for register r:
  - +1 if accepted issue to r.
  - −1 if retire_valid to r.
  - Both in the same cycle on the same r: counter unchanged, no error.
- Saturation:
  - Increment at max (3) holds at 3 and sets overflow_err.
  - Decrement at 0 holds at 0 and sets underflow_err.
  - Error flags clear only on rst.
- busy_mask and in_flight are registered.
  - They reflect counters after the edge: one cycle latency from issue/retire.
  - in_flight = popcount-weighted sum of counters, clamped at 7.
- Load tracking (registers):
  - ld_valid <= accept & issue_mem_read.
  - ld_dest <= issue_dest.
  - Describes the instruction currently in EXE.
  - Cleared when the next cycle accepts nothing or a non-load.
- hazard is combinational from registered state plus ID inputs; it never depends on same-cycle issue/retire.
  - forwardingEnabled=0: hazard = busy(src1) | (twoSrc & busy(src2)), where busy(r) = counter[r] != 0.
  - forwardingEnabled=1: hazard = ld_valid & (src1==ld_dest | (twoSrc & src2==ld_dest)).
  - forwardingEnabled may change any cycle; hazard follows immediately, and the counters keep tracking in both modes.
- Retire in the same cycle as a dependent ID read:
  - Counter is still nonzero that cycle, so hazard=1.
  - Release occurs the following cycle; the register file write-then-read is not relied on.
- rst mid-operation clears all state on that edge, regardless of issue/retire inputs.

Test Plan:
- Reset, then issue R3 (wb_en=1), no forwarding; next cycle src1=3 -> hazard=1, busy_mask=0x0008, in_flight=1; retire R3 -> following cycle hazard=0, busy_mask=0.
- Issue R5 twice on consecutive cycles, retire R5 once -> busy_mask bit5 still 1, in_flight=1; second retire -> bit5=0.
- Same-cycle issue R7 and retire R7 with counter=1 -> counter stays 1, in_flight=1, no error flags.
- forwardingEnabled=1: issue load to R2, next cycle twoSrc=1, src2=2 -> hazard=1; one cycle later (no issue) -> hazard=0 while busy_mask bit2=1.
- forwardingEnabled=1: non-load issue to R4, then src1=4 -> hazard=0.
- Issue R1 four times -> counter 3, overflow_err=1.
- Retire R9 at zero -> underflow_err=1, busy_mask unchanged.
- rst asserted mid-sequence -> all outputs 0 on the next cycle.
